// File: rtl/execute_pipe_pkg.sv
// Shared Y86-64 encodings for the execute stage: icode/ifun values, register "none",
// condition-code bit positions, ALU function enum and the branch/cmov condition evaluator.
// Pure declarations; no state, no timing.
package execute_pipe_pkg;

    // Instruction codes (0x0..0xB are the legal ones)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    // Condition function codes for jXX / cmovXX
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Bit positions inside cc = {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // OPq ifun 0..3 maps directly onto this encoding
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_e;

    // Returns 0 for undefined condition codes; the caller flags them as invalid.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[CC_ZF];
        sf = cc[CC_SF];
        of = cc[CC_OF];
        case (ifun)
            C_ALWAYS: cond_eval = 1'b1;
            C_LE:     cond_eval = (sf ^ of) | zf;
            C_L:      cond_eval = sf ^ of;
            C_E:      cond_eval = zf;
            C_NE:     cond_eval = ~zf;
            C_GE:     cond_eval = ~(sf ^ of);
            C_G:      cond_eval = ~(sf ^ of) & ~zf;
            default:  cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode->execute->memory bundle: request payload with valid/ready, flush, and the E->M result.
// Latency: none (wires only).
// Backpressure: in_ready from the stage, out_ready from the memory stage.
// master = surrounding pipeline (drives requests, consumes results); slave = execute stage.
interface execute_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] valC;
    logic [3:0]       dstE;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_icode;
    logic [WIDTH-1:0] out_valE;
    logic [WIDTH-1:0] out_valA;
    logic [3:0]       out_dstE;
    logic             out_cnd;
    logic             out_ins;
    logic [2:0]       cc;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, dstE, flush, out_ready,
        input  in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_ins, cc
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, dstE, flush, out_ready,
        output in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE, out_cnd, out_ins, cc
    );
endinterface

// File: rtl/execute_pipe_alu.sv
// Combinational Y86 ALU: result = b op a (mod 2^WIDTH) with {ZF,SF,OF} flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the flags are committed.
module execute_pipe_alu
    import execute_pipe_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_fun_e         fun,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);
    logic ovf;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (fun)
            ALU_ADD: begin
                result = b + a;
                // Operands agree in sign but the sum does not
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = b - a;
                // Operands differ in sign and the difference left B's sign
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[CC_ZF] = (result == '0);
        flags[CC_SF] = result[WIDTH-1];
        flags[CC_OF] = ovf;
    end

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: operand select, ALU, CC register, cond eval and registered E->M output.
// Latency: 1 cycle from accept to out_valid; back-to-back throughput of one instr per cycle.
// Backpressure: in_ready = !out_valid | out_ready; stalled outputs and cc hold; flush beats accept.
// Ports: clk, rst_n (async active-low), bus (execute_pipe_if.slave: decode request, flush, E->M result, cc).
module execute_pipe
    import execute_pipe_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic           clk,
    input  logic           rst_n,
    execute_pipe_if.slave  bus
);
    logic             out_valid_q;
    logic [3:0]       out_icode_q;
    logic [WIDTH-1:0] out_valE_q;
    logic [WIDTH-1:0] out_valA_q;
    logic [3:0]       out_dstE_q;
    logic             out_cnd_q;
    logic             out_ins_q;
    logic [2:0]       cc_q;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    alu_fun_e         alu_fun;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flags;
    logic             cc_we;
    logic             cnd;
    logic             ins;
    logic [3:0]       dst_e;

    assign in_ready = !out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready & !bus.flush;

    // Operand select; anything that does not use the ALU leaves a=b=0 so valE=0.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = ALU_ADD;
        cc_we   = 1'b0;
        cnd     = 1'b0;
        ins     = 1'b0;
        dst_e   = bus.dstE;
        case (bus.icode)
            I_HALT, I_NOP: ;
            I_CMOVXX: begin
                alu_a = bus.valA;
                cnd   = cond_eval(bus.ifun, cc_q);
                ins   = (bus.ifun > C_G);
                // Failed move keeps the pipeline flowing but writes nothing
                if (!cnd) dst_e = RNONE;
            end
            I_IRMOVQ: alu_a = bus.valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = bus.valC;
                alu_b = bus.valB;
            end
            I_OPQ: begin
                if (bus.ifun <= 4'd3) begin
                    alu_a   = bus.valA;
                    alu_b   = bus.valB;
                    alu_fun = alu_fun_e'(bus.ifun[1:0]);
                    cc_we   = 1'b1;
                end else begin
                    ins = 1'b1;
                end
            end
            I_JXX: begin
                cnd = cond_eval(bus.ifun, cc_q);
                ins = (bus.ifun > C_G);
            end
            I_CALL, I_PUSHQ: begin
                alu_a   = WIDTH'(8);
                alu_b   = bus.valB;
                alu_fun = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = WIDTH'(8);
                alu_b = bus.valB;
            end
            default: ins = 1'b1;
        endcase
    end

    execute_pipe_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fun    (alu_fun),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= '0;
            out_valE_q  <= '0;
            out_valA_q  <= '0;
            out_dstE_q  <= RNONE;
            out_cnd_q   <= 1'b0;
            out_ins_q   <= 1'b0;
            cc_q        <= CC_RESET;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_icode_q <= bus.icode;
            out_valE_q  <= alu_res;
            out_valA_q  <= bus.valA;
            out_dstE_q  <= dst_e;
            out_cnd_q   <= cnd;
            out_ins_q   <= ins;
            if (cc_we) cc_q <= alu_flags;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.out_valE  = out_valE_q;
    assign bus.out_valA  = out_valA_q;
    assign bus.out_dstE  = out_dstE_q;
    assign bus.out_cnd   = out_cnd_q;
    assign bus.out_ins   = out_ins_q;
    assign bus.cc        = cc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed vector table, stall/flush/reset sequences, a WIDTH=16
// overflow case, and a randomized run against a transaction-level reference model.
module tb_execute_pipe;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic clk;
    logic rst_n;

    execute_pipe_if #(.WIDTH(64)) bus ();
    execute_pipe_if #(.WIDTH(16)) bus16 ();

    execute_pipe #(.WIDTH(64), .CC_RESET(3'b100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    execute_pipe #(.WIDTH(16), .CC_RESET(3'b100)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic        cnd;
        logic        ins;
    } exp_t;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [3:0]  d;
        logic [63:0] e_valE;
        logic [3:0]  e_dstE;
        logic        e_cnd;
        logic        e_ins;
        logic [2:0]  e_cc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[20];
    exp_t q[$];
    logic [2:0] m_cc;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t cur();
        exp_t g;
        g = '{bus.out_icode, bus.out_valE, bus.out_valA, bus.out_dstE, bus.out_cnd, bus.out_ins};
        return g;
    endfunction

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] d);
        bus.in_valid = v;
        bus.icode    = ic;
        bus.ifun     = fn;
        bus.valA     = a;
        bus.valB     = b;
        bus.valC     = c;
        bus.dstE     = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: instruction semantics written from the ISA rules with wide signed arithmetic.
    function automatic void ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [3:0] d,
                                     input logic [2:0] ccin, output exp_t e,
                                     output logic [2:0] ccout);
        logic zf, sf, of, take, ovf;
        logic [64:0] wide;
        zf = ccin[2]; sf = ccin[1]; of = ccin[0];
        e = '{ic, 64'd0, a, d, 1'b0, 1'b0};
        ccout = ccin;
        ovf = 1'b0;
        wide = '0;
        case (fn)
            4'd0: take = 1'b1;
            4'd1: take = (sf != of) || zf;
            4'd2: take = (sf != of);
            4'd3: take = zf;
            4'd4: take = !zf;
            4'd5: take = (sf == of);
            4'd6: take = (sf == of) && !zf;
            default: take = 1'b0;
        endcase
        case (ic)
            4'h0, 4'h1: e.valE = 64'd0;
            4'h2: begin
                e.valE = a;
                if (fn > 4'd6) e.ins = 1'b1;
                else           e.cnd = take;
                if (!e.cnd) e.dstE = 4'hF;
            end
            4'h3: e.valE = c;
            4'h4, 4'h5: e.valE = b + c;
            4'h6: begin
                case (fn)
                    4'd0: begin wide = {b[63], b} + {a[63], a}; e.valE = wide[63:0]; ovf = wide[64] != wide[63]; end
                    4'd1: begin wide = {b[63], b} - {a[63], a}; e.valE = wide[63:0]; ovf = wide[64] != wide[63]; end
                    4'd2: e.valE = a & b;
                    4'd3: e.valE = a ^ b;
                    default: e.ins = 1'b1;
                endcase
                if (fn <= 4'd3) ccout = {e.valE == 64'd0, e.valE[63], ovf};
            end
            4'h7: begin
                if (fn > 4'd6) e.ins = 1'b1;
                else           e.cnd = take;
            end
            4'h8, 4'hA: e.valE = b - 64'd8;
            4'h9, 4'hB: e.valE = b + 64'd8;
            default: e.ins = 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return MAXP;
            3: return MINN;
            4: return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        exp_t e, got;
        logic [2:0] ncc;
        logic iv, ordy, fl, exp_valid;
        logic [3:0] ic, fn, d;
        logic [63:0] a, b, c;

        //               ic    fn    A            B          C        d      valE                 dstE   cnd   ins   cc
        tbl[0]  = '{4'h6, 4'h0, 64'd3,      64'd5,     64'd0,    4'h2, 64'd8,               4'h2, 1'b0, 1'b0, 3'b000};
        tbl[1]  = '{4'h6, 4'h1, 64'h10,     64'h10,    64'd0,    4'h2, 64'd0,               4'h2, 1'b0, 1'b0, 3'b100};
        tbl[2]  = '{4'h7, 4'h1, 64'd0,      64'd0,     64'h40,   4'hF, 64'd0,               4'hF, 1'b1, 1'b0, 3'b100};
        tbl[3]  = '{4'h7, 4'h6, 64'd0,      64'd0,     64'h40,   4'hF, 64'd0,               4'hF, 1'b0, 1'b0, 3'b100};
        tbl[4]  = '{4'h2, 4'h4, 64'h55,     64'd0,     64'd0,    4'h3, 64'h55,              4'hF, 1'b0, 1'b0, 3'b100};
        tbl[5]  = '{4'h6, 4'h0, 64'd1,      MAXP,      64'd0,    4'h4, MINN,                4'h4, 1'b0, 1'b0, 3'b011};
        tbl[6]  = '{4'h2, 4'h4, 64'hABCD,   64'd0,     64'd0,    4'h3, 64'hABCD,            4'h3, 1'b1, 1'b0, 3'b011};
        tbl[7]  = '{4'hC, 4'h0, 64'd9,      64'd9,     64'd9,    4'h5, 64'd0,               4'h5, 1'b0, 1'b1, 3'b011};
        tbl[8]  = '{4'hA, 4'h0, 64'd0,      64'h100,   64'd0,    4'h4, 64'hF8,              4'h4, 1'b0, 1'b0, 3'b011};
        tbl[9]  = '{4'hB, 4'h0, 64'd0,      64'h100,   64'd0,    4'h4, 64'h108,             4'h4, 1'b0, 1'b0, 3'b011};
        tbl[10] = '{4'h3, 4'h0, 64'd0,      64'd0,     64'h1234, 4'h1, 64'h1234,            4'h1, 1'b0, 1'b0, 3'b011};
        tbl[11] = '{4'h5, 4'h0, 64'd0,      64'h1000,  64'h20,   4'h6, 64'h1020,            4'h6, 1'b0, 1'b0, 3'b011};
        tbl[12] = '{4'h6, 4'h3, 64'hF0,     64'hFF,    64'd0,    4'h1, 64'h0F,              4'h1, 1'b0, 1'b0, 3'b000};
        tbl[13] = '{4'h6, 4'h2, 64'hF0,     64'h0F,    64'd0,    4'h1, 64'd0,               4'h1, 1'b0, 1'b0, 3'b100};
        tbl[14] = '{4'h7, 4'h7, 64'd0,      64'd0,     64'h40,   4'hF, 64'd0,               4'hF, 1'b0, 1'b1, 3'b100};
        tbl[15] = '{4'h6, 4'h1, 64'd1,      MINN,      64'd0,    4'h2, MAXP,                4'h2, 1'b0, 1'b0, 3'b001};
        tbl[16] = '{4'h7, 4'h2, 64'd0,      64'd0,     64'h80,   4'hF, 64'd0,               4'hF, 1'b1, 1'b0, 3'b001};
        tbl[17] = '{4'h8, 4'h0, 64'd0,      64'h200,   64'd0,    4'h4, 64'h1F8,             4'h4, 1'b0, 1'b0, 3'b001};
        tbl[18] = '{4'h4, 4'h0, 64'd7,      64'h10,    64'h8,    4'hF, 64'h18,              4'hF, 1'b0, 1'b0, 3'b001};
        tbl[19] = '{4'h0, 4'h0, 64'd0,      64'd0,     64'd0,    4'hF, 64'd0,               4'hF, 1'b0, 1'b0, 3'b001};

        // ---------------- reset values
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.icode = '0; bus16.ifun = '0;
        bus16.valA = '0; bus16.valB = '0; bus16.valC = '0; bus16.dstE = 4'hF;
        bus16.flush = 1'b0; bus16.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_payload", cur(), exp_t'{4'h0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0});
        check("rst_cc", bus.cc, 3'b100);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;

        // ---------------- directed vector table, one instruction per cycle
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, tbl[i].icode, tbl[i].ifun, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            tick();
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
            check($sformatf("vec%0d_payload", i), cur(),
                  exp_t'{tbl[i].icode, tbl[i].e_valE, tbl[i].a, tbl[i].e_dstE, tbl[i].e_cnd, tbl[i].e_ins});
            check($sformatf("vec%0d_cc", i), bus.cc, tbl[i].e_cc);
        end

        // ---------------- backpressure: 3 stalled cycles, nothing dropped, order kept
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF);
        tick();
        check("drain_valid", bus.out_valid, 1'b0);
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);   // addq 1+1
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready_empty", bus.in_ready, 1'b1);
        tick();
        drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd1, 64'd0, 4'h3);   // subq 1-5
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_in_ready", k), bus.in_ready, 1'b0);
            check($sformatf("bp%0d_valid", k), bus.out_valid, 1'b1);
            check($sformatf("bp%0d_payload", k), cur(), exp_t'{4'h6, 64'd2, 64'd1, 4'h2, 1'b0, 1'b0});
            check($sformatf("bp%0d_cc", k), bus.cc, 3'b000);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_next_payload", cur(), exp_t'{4'h6, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 4'h3, 1'b0, 1'b0});
        check("bp_next_cc", bus.cc, 3'b010);
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF);
        tick();
        check("bp_drained", bus.out_valid, 1'b0);

        // ---------------- flush beats accept, cc untouched
        drive(1'b1, 4'h6, 4'h0, 64'd2, 64'd2, 64'd0, 4'h1);
        tick();
        check("fl_pre_valid", bus.out_valid, 1'b1);
        check("fl_pre_cc", bus.cc, 3'b000);
        drive(1'b1, 4'h6, 4'h0, MINN, MINN, 64'd0, 4'h1);     // would set cc=101
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF);
        check("fl_valid", bus.out_valid, 1'b0);
        check("fl_cc", bus.cc, 3'b000);

        // ---------------- asynchronous reset mid-stream
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h1);
        tick();
        check("ar_pre_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", bus.out_valid, 1'b0);
        check("ar_payload", cur(), exp_t'{4'h0, 64'd0, 64'd0, 4'hF, 1'b0, 1'b0});
        check("ar_cc", bus.cc, 3'b100);
        drive(1'b0, 4'h0, 4'h0, '0, '0, '0, 4'hF);
        tick();
        rst_n = 1'b1;

        // ---------------- WIDTH=16 signed overflow on add
        bus16.in_valid = 1'b1; bus16.icode = 4'h6; bus16.ifun = 4'h0;
        bus16.valA = 16'h0001; bus16.valB = 16'h7FFF; bus16.dstE = 4'h2;
        tick();
        bus16.in_valid = 1'b0;
        check("w16_valid", bus16.out_valid, 1'b1);
        check("w16_valE", bus16.out_valE, 16'h8000);
        check("w16_cc", bus16.cc, 3'b011);

        // ---------------- randomized run against the reference model
        m_cc = 3'b100;
        q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            ic   = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            fn   = 4'($urandom_range(0, 7));
            a    = pick();
            b    = pick();
            c    = pick();
            d    = 4'($urandom_range(0, 15));
            drive(iv, ic, fn, a, b, c, d);
            bus.flush     = fl;
            bus.out_ready = ordy;
            #1;
            exp_valid = (q.size() != 0);
            check("rnd_out_valid", bus.out_valid, exp_valid);
            check("rnd_in_ready", bus.in_ready, !exp_valid || ordy);
            if (exp_valid) begin
                got = cur();
                check("rnd_payload", got, q[0]);
            end
            check("rnd_cc", bus.cc, m_cc);
            if (fl) begin
                q.delete();
            end else begin
                if (exp_valid && ordy) void'(q.pop_front());
                if (iv && (!exp_valid || ordy)) begin
                    ref_exec(ic, fn, a, b, c, d, m_cc, e, ncc);
                    q.push_back(e);
                    m_cc = ncc;
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
